// File: rtl/nw_systolic_aligner.sv
// rtl/nw_systolic_aligner.sv - Needleman-Wunsch aligner: systolic PE row, direction store, traceback stream
// One PE per s2 column sweeps the anti-diagonal wavefront; traceback walks the stored directions.
module nw_systolic_aligner #(
  parameter int MAX_LEN     = 16,
  parameter int CWIDTH      = 2,
  parameter int SWIDTH      = 16,
  parameter int CORD_LENGTH = 8,
  parameter int WWIDTH      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CORD_LENGTH-1:0]      len1,
  input  logic [CORD_LENGTH-1:0]      len2,
  input  logic [MAX_LEN*CWIDTH-1:0]   s1,
  input  logic [MAX_LEN*CWIDTH-1:0]   s2,
  input  logic signed [WWIDTH-1:0]    w_match,
  input  logic signed [WWIDTH-1:0]    w_mismatch,
  input  logic signed [WWIDTH-1:0]    w_indel,
  output logic                        busy,
  output logic                        err,
  output logic signed [SWIDTH-1:0]    score,
  output logic                        score_valid,
  output logic                        path_valid,
  input  logic                        path_ready,
  output logic [CORD_LENGTH-1:0]      path_x,
  output logic [CORD_LENGTH-1:0]      path_y,
  output logic [1:0]                  path_dir,
  output logic                        path_last
);

  localparam int CW = CORD_LENGTH;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PW = SWIDTH + CW + 2;
  localparam logic signed [PW-1:0] SMAX = {{(PW-SWIDTH+1){1'b0}}, {(SWIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, FILL, SCORE, TRACE} state_t;

  function automatic logic signed [PW-1:0] sx(input logic signed [SWIDTH-1:0] a);
    return {{(PW-SWIDTH){a[SWIDTH-1]}}, a};
  endfunction

  function automatic logic signed [PW-1:0] wx(input logic signed [WWIDTH-1:0] w);
    return {{(PW-WWIDTH){w[WWIDTH-1]}}, w};
  endfunction

  function automatic logic signed [SWIDTH-1:0] clamp(input logic signed [PW-1:0] v);
    if (v > SMAX) return SMAX[SWIDTH-1:0];
    else if (v < SMIN) return SMIN[SWIDTH-1:0];
    else return v[SWIDTH-1:0];
  endfunction

  function automatic logic signed [SWIDTH-1:0] add(input logic signed [SWIDTH-1:0] a,
                                                   input logic signed [PW-1:0] b);
    return clamp(sx(a) + b);
  endfunction

  function automatic logic signed [SWIDTH-1:0] times(input logic [CW:0] n,
                                                     input logic signed [WWIDTH-1:0] w);
    logic signed [PW-1:0] p;
    p = $signed({{(PW-CW-1){1'b0}}, n}) * wx(w);
    return clamp(p);
  endfunction

  state_t state_q, state_d;
  logic [CW:0]                 t_q;
  logic [CW-1:0]               len1_q, len2_q, x_q, y_q;
  logic [MAX_LEN*CWIDTH-1:0]   s1_q, s2_q;
  logic signed [WWIDTH-1:0]    wm_q, wmm_q, wi_q;
  logic                        err_q, sv_q, pv_q;
  logic signed [SWIDTH-1:0]    score_q;

  logic signed [SWIDTH-1:0]    h_w  [MAX_LEN];
  logic signed [SWIDTH-1:0]    hp_w [MAX_LEN];
  logic [2*MAX_LEN-1:0]        dcol_w [MAX_LEN];

  logic fill_en, len_ok, fill_done, at_origin, accept;
  logic [1:0] dir_cur;

  always_comb begin
    len_ok    = (len1 != '0) && (len1 <= CW'(MAX_LEN)) && (len2 != '0) && (len2 <= CW'(MAX_LEN));
    fill_done = (t_q == ({1'b0, len1_q} + {1'b0, len2_q} - (CW+1)'(2)));
    at_origin = (x_q == '0) && (y_q == '0);
    accept    = pv_q && path_ready;
    dir_cur   = dcol_w[x_q[IW-1:0]][y_q[IW-1:0]*2 +: 2];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && len_ok) state_d = FILL;
      FILL:    if (fill_done) state_d = SCORE;
      SCORE:   state_d = TRACE;
      TRACE:   if (accept && at_origin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    fill_en     = (state_q == FILL);
    err         = err_q;
    score       = score_q;
    score_valid = sv_q;
    path_valid  = pv_q;
    path_x      = x_q;
    path_y      = y_q;
    path_dir    = pv_q ? dir_cur : 2'b00;
    path_last   = pv_q && at_origin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q <= '0; len1_q <= '0; len2_q <= '0; s1_q <= '0; s2_q <= '0;
      wm_q <= '0; wmm_q <= '0; wi_q <= '0;
      err_q <= 1'b0; sv_q <= 1'b0; pv_q <= 1'b0; score_q <= '0;
      x_q <= '0; y_q <= '0;
    end else begin
      err_q <= 1'b0;
      sv_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (len_ok) begin
            len1_q <= len1; len2_q <= len2; s1_q <= s1; s2_q <= s2;
            wm_q <= w_match; wmm_q <= w_mismatch; wi_q <= w_indel;
            t_q <= '0;
          end else begin
            err_q <= 1'b1;
          end
        end
        FILL: t_q <= t_q + (CW+1)'(1);
        SCORE: begin
          score_q <= h_w[len2_q[IW-1:0] - IW'(1)];
          sv_q    <= 1'b1;
          x_q     <= len2_q - CW'(1);
          y_q     <= len1_q - CW'(1);
          pv_q    <= 1'b1;
        end
        TRACE: if (accept) begin
          if (at_origin)       pv_q <= 1'b0;
          else if (x_q == '0)  y_q <= y_q - CW'(1);
          else if (y_q == '0)  x_q <= x_q - CW'(1);
          else begin
            case (dir_cur)
              2'b00:   y_q <= y_q - CW'(1);
              2'b01:   x_q <= x_q - CW'(1);
              default: begin x_q <= x_q - CW'(1); y_q <= y_q - CW'(1); end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // PE j owns column j: its score register, the value before it (corner for PE j+1), and its directions.
  for (genvar j = 0; j < MAX_LEN; j++) begin : g_pe
    localparam int JP = (j == 0) ? 0 : j - 1;
    logic [CW:0]              row;
    logic                     act, match;
    logic signed [SWIDTH-1:0] above, left, corner, c_s, t_s, l_s, h_d, h_q, hp_q;
    logic [1:0]               dsel;
    logic [2*MAX_LEN-1:0]     dcol_q;

    always_comb begin
      row   = t_q - (CW+1)'(j);
      act   = fill_en && (t_q >= (CW+1)'(j)) && (row < {1'b0, len1_q}) && (CW'(j) < len2_q);
      match = (s1_q[row[IW-1:0]*CWIDTH +: CWIDTH] == s2_q[j*CWIDTH +: CWIDTH]);
      above = (row == '0) ? times((CW+1)'(j+1), wi_q) : h_q;
      left  = (j == 0) ? times(row + (CW+1)'(1), wi_q) : h_w[JP];
      if (row == '0 && j == 0) corner = '0;
      else if (row == '0)      corner = times((CW+1)'(j), wi_q);
      else if (j == 0)         corner = times(row, wi_q);
      else                     corner = hp_w[JP];
      c_s = add(corner, wx(match ? wm_q : wmm_q));
      t_s = add(above, wx(wi_q));
      l_s = add(left, wx(wi_q));
      if (c_s >= t_s && c_s >= l_s) begin h_d = c_s; dsel = 2'b10; end
      else if (t_s >= l_s)          begin h_d = t_s; dsel = 2'b00; end
      else                          begin h_d = l_s; dsel = 2'b01; end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        h_q  <= '0;
        hp_q <= '0;
      end else if (act) begin
        hp_q <= h_q;
        h_q  <= h_d;
      end
    end

    always_ff @(posedge clk) begin
      if (act) dcol_q[row[IW-1:0]*2 +: 2] <= dsel;
    end

    assign h_w[j]    = h_q;
    assign hp_w[j]   = hp_q;
    assign dcol_w[j] = dcol_q;
  end

endmodule

// File: tb/tb_nw_systolic_aligner.sv
// tb/tb_nw_systolic_aligner.sv - table-driven scoreboard bench for nw_systolic_aligner
module tb_nw_systolic_aligner;
  localparam int ML = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        len1 = '0, len2 = '0;
  logic [ML*2-1:0]   s1 = '0, s2 = '0;
  logic signed [3:0] w_match = '0, w_mismatch = '0, w_indel = '0;
  logic              busy, err, score_valid, path_valid, path_last;
  logic              path_ready = 1'b1;
  logic signed [15:0] score;
  logic [7:0]        path_x, path_y;
  logic [1:0]        path_dir;

  nw_systolic_aligner dut (
    .clk(clk), .reset(reset), .start(start), .len1(len1), .len2(len2),
    .s1(s1), .s2(s2), .w_match(w_match), .w_mismatch(w_mismatch), .w_indel(w_indel),
    .busy(busy), .err(err), .score(score), .score_valid(score_valid),
    .path_valid(path_valid), .path_ready(path_ready), .path_x(path_x), .path_y(path_y),
    .path_dir(path_dir), .path_last(path_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l1, l2;
    string a, b;
    int wm, wmm, wi, score, nb;
    logic [7:0][3:0] bx, by;
    logic [7:0][1:0] bd;
  } vec_t;

  typedef struct { int x, y, d; bit last; } beat_t;

  vec_t  tv [5];
  beat_t sb [$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ML*2-1:0] enc(input string s);
    logic [ML*2-1:0] r = '0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "C":     r[i*2 +: 2] = 2'd1;
        "G":     r[i*2 +: 2] = 2'd2;
        "T":     r[i*2 +: 2] = 2'd3;
        default: r[i*2 +: 2] = 2'd0;
      endcase
    end
    return r;
  endfunction

  task automatic set_vec(input int v, input int l1, input int l2, input string a, input string b,
                         input int wm, input int wmm, input int wi, input int sc);
    tv[v].l1 = l1; tv[v].l2 = l2; tv[v].a = a; tv[v].b = b;
    tv[v].wm = wm; tv[v].wmm = wmm; tv[v].wi = wi; tv[v].score = sc; tv[v].nb = 0;
  endtask

  task automatic add_beat(input int v, input int x, input int y, input int d);
    tv[v].bx[tv[v].nb] = 4'(x);
    tv[v].by[tv[v].nb] = 4'(y);
    tv[v].bd[tv[v].nb] = 2'(d);
    tv[v].nb++;
  endtask

  task automatic launch(input int v);
    beat_t e;
    len1 = 8'(tv[v].l1); len2 = 8'(tv[v].l2);
    s1 = enc(tv[v].a); s2 = enc(tv[v].b);
    w_match = 4'(tv[v].wm); w_mismatch = 4'(tv[v].wmm); w_indel = 4'(tv[v].wi);
    start = 1'b1;
    for (int k = 0; k < tv[v].nb; k++) begin
      e.x = int'(tv[v].bx[k]); e.y = int'(tv[v].by[k]); e.d = int'(tv[v].bd[k]);
      e.last = (k == tv[v].nb - 1);
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
    // scramble the job inputs to show they were captured at start
    s1 = ML*2'($urandom); s2 = ML*2'($urandom);
    w_match = 4'($urandom); w_mismatch = 4'($urandom); w_indel = 4'($urandom);
    len1 = 8'($urandom); len2 = 8'($urandom);
  endtask

  task automatic run_job(input int v, input int stall_at);
    int cyc, idx, st;
    bit done;
    beat_t e;
    path_ready = 1'b1;
    launch(v);
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (!score_valid && cyc < 100) begin tick(); cyc++; end
    chk("score_latency", cyc, tv[v].l1 + tv[v].l2);
    chk("score", score, tv[v].score);
    idx = 0; st = 0; done = 0; cyc = 0;
    while (!done && cyc < 100) begin
      if (idx == stall_at && st < 5) begin
        path_ready = 1'b0;
        if (path_valid && sb.size() > 0) begin
          chk("stall_x", path_x, sb[0].x);
          chk("stall_y", path_y, sb[0].y);
          chk("stall_dir", path_dir, sb[0].d);
        end
        st++;
      end else begin
        path_ready = 1'b1;
        if (path_valid) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("beat_x", path_x, e.x);
            chk("beat_y", path_y, e.y);
            chk("beat_dir", path_dir, e.d);
            chk("beat_last", path_last, e.last);
            done = e.last;
            idx++;
          end
        end
      end
      tick();
      cyc++;
    end
    chk("path_done", done, 1);
    chk("valid_drop", path_valid, 0);
    chk("busy_drop", busy, 0);
    chk("sb_empty", sb.size(), 0);
    chk("score_held", score, tv[v].score);
  endtask

  task automatic bad_start(input int l1, input int l2);
    len1 = 8'(l1); len2 = 8'(l2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    tick();
    chk("err_clear", err, 0);
    chk("err_busy2", busy, 0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_score_valid"}, score_valid, 0);
    chk({tag, "_path_valid"}, path_valid, 0);
    chk({tag, "_path_x"}, path_x, 0);
    chk({tag, "_path_y"}, path_y, 0);
    chk({tag, "_path_dir"}, path_dir, 0);
    chk({tag, "_path_last"}, path_last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int cyc;
    set_vec(0, 4, 4, "ACGT", "ACGT", 1, -1, -1, 4);
    add_beat(0, 3, 3, 2); add_beat(0, 2, 2, 2); add_beat(0, 1, 1, 2); add_beat(0, 0, 0, 2);
    set_vec(1, 3, 3, "AAA", "CCC", 1, -1, -1, -3);
    add_beat(1, 2, 2, 2); add_beat(1, 1, 1, 2); add_beat(1, 0, 0, 2);
    set_vec(2, 2, 4, "AC", "ACGT", 1, -1, -1, 0);
    add_beat(2, 3, 1, 1); add_beat(2, 2, 1, 1); add_beat(2, 1, 1, 2); add_beat(2, 0, 0, 2);
    set_vec(3, 1, 1, "A", "C", 2, -3, -1, -2);
    add_beat(3, 0, 0, 0);
    set_vec(4, 3, 1, "ACG", "G", 1, -1, -1, -1);
    add_beat(4, 0, 2, 2); add_beat(4, 0, 1, 2); add_beat(4, 0, 0, 2);

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_cleared("reset");

    for (int v = 0; v < 5; v++) run_job(v, -1);

    run_job(0, 1);

    bad_start(0, 4);
    bad_start(4, ML + 1);

    // reset during traceback, then a fresh job
    launch(0);
    cyc = 0;
    while (!score_valid && cyc < 100) begin tick(); cyc++; end
    chk("rst_job_score_seen", score_valid, 1);
    path_ready = 1'b1;
    tick();
    path_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_cleared("midreset");
    sb.delete();
    run_job(1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
